// File: rtl/exp_io_mailbox_if.sv
// CPU expansion-bus and host byte-stream signals of the I/O mailbox.
// The slave modport is the peripheral's view; master is the motherboard/host side.
interface exp_io_mailbox_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        iorq;
    logic        rd;
    logic        wr;
    logic        m1;
    logic [7:0]  cpu_din;
    logic        irq;

    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    modport master (
        output cpu_addr, cpu_dout, iorq, rd, wr, m1, tx_ready, rx_data, rx_valid,
        input  cpu_din, irq, tx_data, tx_valid, rx_ready
    );

    modport slave (
        input  cpu_addr, cpu_dout, iorq, rd, wr, m1, tx_ready, rx_data, rx_valid,
        output cpu_din, irq, tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/exp_io_mailbox.sv
// Z80 I/O-port mailbox: data port pushes TX / pops RX, status/control port at BASE+1,
// with two circular byte FIFOs shared with host-side logic and a level interrupt.
module exp_io_mailbox #(
    parameter logic [7:0]  BASE  = 8'hD0,
    parameter int unsigned DEPTH = 16
) (
    input logic             clk,
    input logic             reset,
    exp_io_mailbox_if.slave bus
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    // Bus decode and strobe edge detection
    logic hit, a0, io_w, io_r;
    logic io_w_q, io_w_d, io_r_q, io_r_d;
    logic w_rise, r_rise, r_fall;
    logic data_wr, ctrl_wr, flush, clr_ovf;

    // TX FIFO (Z80 -> host)
    logic [7:0]      tx_mem_q [DEPTH];
    logic [7:0]      tx_mem_d [DEPTH];
    logic [PtrW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic            tx_full, tx_empty, tx_push, tx_pop, tx_ovf_set;

    // RX FIFO (host -> Z80)
    logic [7:0]      rx_mem_q [DEPTH];
    logic [7:0]      rx_mem_d [DEPTH];
    logic [PtrW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic            rx_full, rx_empty, rx_push, rx_pop, rx_ovf_set;

    // Control/status and outputs
    logic       irq_en_q, irq_en_d;
    logic       tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic       rd_pend_q, rd_pend_d;
    logic [7:0] cpu_din_q, cpu_din_d;
    logic       irq_q, irq_d;
    logic [7:0] status;

    always_comb begin
        hit  = (bus.cpu_addr[15:8] == 8'hFB) && (bus.cpu_addr[7:1] == BASE[7:1]);
        a0   = bus.cpu_addr[0];
        io_w = bus.iorq & bus.wr & ~bus.m1 & hit;
        io_r = bus.iorq & bus.rd & ~bus.m1 & hit;

        io_w_d = io_w;
        io_r_d = io_r;
        w_rise = io_w & ~io_w_q;
        r_rise = io_r & ~io_r_q;
        r_fall = ~io_r & io_r_q;

        data_wr = w_rise & ~a0;
        ctrl_wr = w_rise & a0;
        flush   = ctrl_wr & bus.cpu_dout[5];
        clr_ovf = ctrl_wr & bus.cpu_dout[6];
    end

    // Handshake and overflow decisions use the pre-cycle counts.
    always_comb begin
        tx_full  = (tx_cnt_q == FullCnt);
        tx_empty = (tx_cnt_q == '0);
        rx_full  = (rx_cnt_q == FullCnt);
        rx_empty = (rx_cnt_q == '0);

        tx_pop     = ~tx_empty & bus.tx_ready;
        tx_push    = data_wr & (~tx_full | tx_pop);
        tx_ovf_set = data_wr & tx_full & ~tx_pop;

        rx_push    = bus.rx_valid & ~rx_full;
        rx_ovf_set = bus.rx_valid & rx_full;
        rx_pop     = r_fall & rd_pend_q & ~rx_empty;
    end

    always_comb begin
        tx_mem_d  = tx_mem_q;
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        if (flush) begin
            tx_wptr_d = '0;
            tx_rptr_d = '0;
            tx_cnt_d  = '0;
        end else begin
            if (tx_push) begin
                tx_mem_d[tx_wptr_q] = bus.cpu_dout;
                tx_wptr_d           = tx_wptr_q + 1'b1;
            end
            if (tx_pop) begin
                tx_rptr_d = tx_rptr_q + 1'b1;
            end
            if (tx_push && !tx_pop) begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end else if (tx_pop && !tx_push) begin
                tx_cnt_d = tx_cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        rx_mem_d  = rx_mem_q;
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        if (flush) begin
            rx_wptr_d = '0;
            rx_rptr_d = '0;
            rx_cnt_d  = '0;
        end else begin
            if (rx_push) begin
                rx_mem_d[rx_wptr_q] = bus.rx_data;
                rx_wptr_d           = rx_wptr_q + 1'b1;
            end
            if (rx_pop) begin
                rx_rptr_d = rx_rptr_q + 1'b1;
            end
            if (rx_push && !rx_pop) begin
                rx_cnt_d = rx_cnt_q + 1'b1;
            end else if (rx_pop && !rx_push) begin
                rx_cnt_d = rx_cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        status = {irq_en_q, 3'b000, tx_ovf_q, rx_ovf_q, ~tx_full, ~rx_empty};

        irq_en_d = ctrl_wr ? bus.cpu_dout[7] : irq_en_q;
        tx_ovf_d = (tx_ovf_q & ~clr_ovf) | tx_ovf_set;
        rx_ovf_d = (rx_ovf_q & ~clr_ovf) | rx_ovf_set;

        // A read that found RX empty must not pop a byte that arrives before it ends.
        rd_pend_d = rd_pend_q;
        if (r_fall || flush) begin
            rd_pend_d = 1'b0;
        end
        if (r_rise && !a0) begin
            rd_pend_d = ~rx_empty;
        end

        cpu_din_d = 8'hFF;
        if (io_r) begin
            if (a0) begin
                cpu_din_d = status;
            end else if (!rx_empty) begin
                cpu_din_d = rx_mem_q[rx_rptr_q];
            end
        end

        irq_d = irq_en_q & ~rx_empty;
    end

    // History registers reset high so a strobe held through reset is never seen as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            io_w_q    <= 1'b1;
            io_r_q    <= 1'b1;
            tx_mem_q  <= '{default: '0};
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_mem_q  <= '{default: '0};
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            irq_en_q  <= 1'b0;
            tx_ovf_q  <= 1'b0;
            rx_ovf_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            cpu_din_q <= 8'hFF;
            irq_q     <= 1'b0;
        end else begin
            io_w_q    <= io_w_d;
            io_r_q    <= io_r_d;
            tx_mem_q  <= tx_mem_d;
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_mem_q  <= rx_mem_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
            irq_en_q  <= irq_en_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_ovf_q  <= rx_ovf_d;
            rd_pend_q <= rd_pend_d;
            cpu_din_q <= cpu_din_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.cpu_din  = cpu_din_q;
    assign bus.irq      = irq_q;
    assign bus.tx_data  = tx_mem_q[tx_rptr_q];
    assign bus.tx_valid = ~tx_empty;
    assign bus.rx_ready = ~rx_full;

endmodule

// File: tb/tb_exp_io_mailbox.sv
// Bench for exp_io_mailbox: directed scenarios plus random traffic checked against
// a queue-based model of the two mailboxes and the status/control register.
module tb_exp_io_mailbox;

    localparam int unsigned Depth = 16;
    localparam logic [15:0] AddrData = 16'hFBD0;
    localparam logic [15:0] AddrStat = 16'hFBD1;
    localparam logic [15:0] AddrMiss = 16'hFBD2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exp_io_mailbox_if bus ();

    exp_io_mailbox #(
        .BASE  (8'hD0),
        .DEPTH (Depth)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit m_irq_en, m_tx_ovf, m_rx_ovf;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_status();
        return {m_irq_en, 3'b000, m_tx_ovf, m_rx_ovf, tx_q.size() < Depth, rx_q.size() != 0};
    endfunction

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        m_irq_en = 0;
        m_tx_ovf = 0;
        m_rx_ovf = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_txv"}, 8'(bus.tx_valid), 8'(tx_q.size() != 0));
        if (tx_q.size() != 0) check_eq({tag, "_txd"}, bus.tx_data, tx_q[0]);
        check_eq({tag, "_rxr"}, 8'(bus.rx_ready), 8'(rx_q.size() < Depth));
        check_eq({tag, "_irq"}, 8'(bus.irq), 8'(m_irq_en && rx_q.size() != 0));
    endtask

    task automatic z80_write(input logic [15:0] addr, input logic [7:0] d);
        bus.cpu_addr = addr;
        bus.cpu_dout = d;
        bus.iorq = 1;
        bus.wr = 1;
        repeat (3) tick();
        bus.iorq = 0;
        bus.wr = 0;
        repeat (2) tick();
        if (addr == AddrData) begin
            if (tx_q.size() >= Depth) m_tx_ovf = 1;
            else tx_q.push_back(d);
        end else if (addr == AddrStat) begin
            m_irq_en = d[7];
            if (d[6]) begin
                m_tx_ovf = 0;
                m_rx_ovf = 0;
            end
            if (d[5]) begin
                tx_q.delete();
                rx_q.delete();
            end
        end
    endtask

    task automatic z80_read(input logic [15:0] addr, input string tag);
        logic [7:0] exp;
        if (addr == AddrData) exp = (rx_q.size() != 0) ? rx_q[0] : 8'hFF;
        else if (addr == AddrStat) exp = model_status();
        else exp = 8'hFF;
        bus.cpu_addr = addr;
        bus.iorq = 1;
        bus.rd = 1;
        tick();
        check_eq({tag, "_first"}, bus.cpu_din, exp);
        repeat (2) tick();
        check_eq({tag, "_last"}, bus.cpu_din, exp);
        bus.iorq = 0;
        bus.rd = 0;
        tick();
        check_eq({tag, "_idle"}, bus.cpu_din, 8'hFF);
        tick();
        if (addr == AddrData && rx_q.size() != 0) void'(rx_q.pop_front());
    endtask

    task automatic host_push(input logic [7:0] d);
        bus.rx_data = d;
        bus.rx_valid = 1;
        tick();
        bus.rx_valid = 0;
        tick();
        if (rx_q.size() < Depth) rx_q.push_back(d);
        else m_rx_ovf = 1;
    endtask

    task automatic host_pop(input string tag);
        check_eq({tag, "_txv"}, 8'(bus.tx_valid), 8'(tx_q.size() != 0));
        if (tx_q.size() != 0) begin
            check_eq({tag, "_txd"}, bus.tx_data, tx_q[0]);
            bus.tx_ready = 1;
            tick();
            bus.tx_ready = 0;
            void'(tx_q.pop_front());
            tick();
        end
    endtask

    initial begin
        reset = 1;
        bus.cpu_addr = '0;
        bus.cpu_dout = '0;
        bus.iorq = 0;
        bus.rd = 0;
        bus.wr = 0;
        bus.m1 = 0;
        bus.tx_ready = 0;
        bus.rx_data = '0;
        bus.rx_valid = 0;
        model_reset();
        repeat (3) tick();
        reset = 0;
        tick();

        // Reset values
        check_eq("rst_cpu_din", bus.cpu_din, 8'hFF);
        check_eq("rst_irq", 8'(bus.irq), 8'h00);
        check_eq("rst_tx_valid", 8'(bus.tx_valid), 8'h00);
        check_eq("rst_tx_data", bus.tx_data, 8'h00);
        check_eq("rst_rx_ready", 8'(bus.rx_ready), 8'h01);

        // Two Z80 writes, then host drains them back to back
        z80_write(AddrData, 8'h41);
        z80_write(AddrData, 8'h42);
        z80_read(AddrStat, "t1_status");
        check_eq("t1_txv", 8'(bus.tx_valid), 8'h01);
        check_eq("t1_txd", bus.tx_data, 8'h41);
        bus.tx_ready = 1;
        check_eq("t1_h0", bus.tx_data, 8'h41);
        tick();
        check_eq("t1_h1", bus.tx_data, 8'h42);
        tick();
        bus.tx_ready = 0;
        check_eq("t1_empty", 8'(bus.tx_valid), 8'h00);
        tx_q.delete();

        // TX overflow: exact drain order, overflow byte dropped
        for (int i = 0; i < Depth; i++) z80_write(AddrData, 8'(i * 5 + 3));
        z80_write(AddrData, 8'hEE);
        z80_read(AddrStat, "t2_status");
        for (int i = 0; i < Depth; i++) host_pop("t2_drain");
        check_eq("t2_empty", 8'(bus.tx_valid), 8'h00);
        z80_write(AddrStat, 8'h40);
        z80_read(AddrStat, "t2_clr");

        // RX byte, interrupt enable, read and irq drop timing
        host_push(8'h5A);
        check_eq("t3_irq_off", 8'(bus.irq), 8'h00);
        z80_write(AddrStat, 8'h80);
        check_eq("t3_irq_on", 8'(bus.irq), 8'h01);
        bus.cpu_addr = AddrData;
        bus.iorq = 1;
        bus.rd = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t3_rd", bus.cpu_din, 8'h5A);
        end
        bus.iorq = 0;
        bus.rd = 0;
        tick();
        check_eq("t3_irq_hold", 8'(bus.irq), 8'h01);
        tick();
        check_eq("t3_irq_drop", 8'(bus.irq), 8'h00);
        void'(rx_q.pop_front());
        z80_read(AddrData, "t3_empty_rd");
        z80_read(AddrStat, "t3_status");

        // Interrupt acknowledge and non-matching address are ignored
        host_push(8'h11);
        bus.cpu_addr = AddrData;
        bus.iorq = 1;
        bus.m1 = 1;
        bus.rd = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t4_inta", bus.cpu_din, 8'hFF);
        end
        bus.iorq = 0;
        bus.m1 = 0;
        bus.rd = 0;
        repeat (2) tick();
        z80_read(AddrStat, "t4_status");
        z80_write(AddrMiss, 8'h99);
        check_eq("t4_miss_w", 8'(bus.tx_valid), 8'h00);
        z80_read(AddrMiss, "t4_miss_r");
        z80_read(AddrData, "t4_data");

        // Flush in the same cycle as a host push
        host_push(8'h01);
        host_push(8'h02);
        host_push(8'h03);
        bus.cpu_addr = AddrStat;
        bus.cpu_dout = 8'h20;
        bus.iorq = 1;
        bus.wr = 1;
        bus.rx_data = 8'h77;
        bus.rx_valid = 1;
        tick();
        bus.rx_valid = 0;
        repeat (2) tick();
        bus.iorq = 0;
        bus.wr = 0;
        repeat (2) tick();
        model_reset();
        check_outputs("t5");
        z80_read(AddrStat, "t5_status");

        // Reset while a write strobe is held high
        z80_write(AddrData, 8'h55);
        bus.cpu_addr = AddrData;
        bus.cpu_dout = 8'h77;
        bus.iorq = 1;
        bus.wr = 1;
        reset = 1;
        tick();
        reset = 0;
        model_reset();
        repeat (3) tick();
        check_eq("t6_no_push", 8'(bus.tx_valid), 8'h00);
        bus.iorq = 0;
        bus.wr = 0;
        repeat (2) tick();
        check_eq("t6_still_empty", 8'(bus.tx_valid), 8'h00);
        z80_write(AddrData, 8'h33);
        check_outputs("t6_after");
        host_pop("t6_pop");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int unsigned op;
            logic [7:0] d;
            op = $urandom_range(0, 9);
            d = 8'($urandom);
            case (op)
                0, 1, 2: z80_write(AddrData, d);
                3:       z80_read(AddrData, "rnd_rd");
                4:       z80_read(AddrStat, "rnd_st");
                5, 6:    host_push(d);
                7:       host_pop("rnd_pop");
                8: begin
                    d[6] = ($urandom_range(0, 3) == 0);
                    d[5] = ($urandom_range(0, 7) == 0);
                    z80_write(AddrStat, d);
                end
                default: repeat (6) host_push(8'($urandom));
            endcase
            check_outputs("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
